// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: syncs board reset, waits for PLL lock, releases mem/periph/core.
// Optional lock-wait timeout is enabled by defining RST_LOCK_TIMEOUT_EN.
module rst_seq_ctrl #(
  parameter int STAGE_DLY  = 16,
  parameter int ASSERT_CYC = 8,
  parameter int CNT_W      = 8,
  parameter int LOCK_TO    = 200
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
  output logic       mem_rst_n,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       rst_busy,
  output logic [3:0] rst_cause
);

  localparam logic [2:0] S_HOLD   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_MEM    = 3'd2;
  localparam logic [2:0] S_PERIPH = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_ASSERT = 3'd5;

  localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] ASRT_LAST = CNT_W'(ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TO - 1);

  logic [1:0]       sync_q;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             byp;
  logic             lock_lost;
  logic             any_req;

  // byp: sequence was forced through by timeout, so ignore lock level
  assign lock_lost = !pll_locked && !byp;
  assign any_req   = lock_lost || wdt_rst_req || sw_rst_req;

`ifdef RST_LOCK_TIMEOUT_EN
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byp <= 1'b0;
    end else if (pll_locked) begin
      byp <= 1'b0;
    end else if (state == S_WAIT && cnt == LOCK_LAST) begin
      byp <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign byp        = 1'b0;
  assign unused_cfg = ^LOCK_LAST;
`endif

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q       <= 2'b00;
      state        <= S_HOLD;
      cnt          <= '0;
      mem_rst_n    <= 1'b0;
      periph_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      rst_busy     <= 1'b1;
      rst_cause    <= 4'b0001;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
      case (state)
        S_HOLD: begin
          cnt <= '0;
          if (sync_q[1]) state <= S_WAIT;
        end
        S_WAIT: begin
          if (pll_locked) begin
            mem_rst_n <= 1'b1;
            cnt       <= '0;
            state     <= S_MEM;
`ifdef RST_LOCK_TIMEOUT_EN
          end else if (cnt == LOCK_LAST) begin
            mem_rst_n <= 1'b1;
            cnt       <= '0;
            state     <= S_MEM;
            rst_cause <= rst_cause | 4'b1000;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        S_MEM, S_PERIPH: begin
          if (lock_lost) begin
            mem_rst_n    <= 1'b0;
            periph_rst_n <= 1'b0;
            core_rst_n   <= 1'b0;
            rst_busy     <= 1'b1;
            rst_cause    <= 4'b1000;
            cnt          <= '0;
            state        <= S_ASSERT;
          end else if (cnt == STG_LAST) begin
            cnt <= '0;
            if (state == S_MEM) begin
              periph_rst_n <= 1'b1;
              state        <= S_PERIPH;
            end else begin
              core_rst_n <= 1'b1;
              rst_busy   <= 1'b0;
              state      <= S_RUN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (any_req) begin
            mem_rst_n    <= 1'b0;
            periph_rst_n <= 1'b0;
            core_rst_n   <= 1'b0;
            rst_busy     <= 1'b1;
            rst_cause    <= {lock_lost, wdt_rst_req, sw_rst_req, 1'b0};
            cnt          <= '0;
            state        <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          if (cnt == ASRT_LAST) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl (STAGE_DLY=4, ASSERT_CYC=3, LOCK_TO=10).
// Define RST_LOCK_TIMEOUT_EN to also exercise the lock-wait timeout.
module tb_rst_seq_ctrl;

  localparam int SD = 4;
  localparam int AC = 3;
  localparam int LT = 10;
`ifdef RST_LOCK_TIMEOUT_EN
  localparam int LOCK_GAP = 5;
`else
  localparam int LOCK_GAP = 20;
`endif

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       wdt_rst_req;
  logic       mem_rst_n;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic       rst_busy;
  logic [3:0] rst_cause;
  logic [7:0] outs;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   base;
  int   c;
  int   d;

  rst_seq_ctrl #(
    .STAGE_DLY (SD),
    .ASSERT_CYC(AC),
    .CNT_W     (8),
    .LOCK_TO   (LT)
  ) dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .pll_locked  (pll_locked),
    .sw_rst_req  (sw_rst_req),
    .wdt_rst_req (wdt_rst_req),
    .mem_rst_n   (mem_rst_n),
    .periph_rst_n(periph_rst_n),
    .core_rst_n  (core_rst_n),
    .rst_busy    (rst_busy),
    .rst_cause   (rst_cause)
  );

  assign outs = {mem_rst_n, periph_rst_n, core_rst_n, rst_busy, rst_cause};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int at, input logic [7:0] v);
    exp_t e;
    e.cyc = at;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [7:0] v);
    checks++;
    if (outs === v) passes++;
    else $display("FAIL %s: got %b want %b", name, outs, v);
  endtask

  // Monitor: every output change must match the next queued expectation
  initial begin : monitor
    logic [7:0] prev;
    exp_t       e;
    prev = 8'b0001_0001;
    forever begin
      @(negedge clk);
      if (outs !== prev) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected: cyc %0d got %b", cyc, outs);
        end else begin
          e = q.pop_front();
          if (outs === e.val && cyc == e.cyc) passes++;
          else $display("FAIL event: got %b@%0d want %b@%0d",
                        outs, cyc, e.val, e.cyc);
        end
        prev = outs;
      end
    end
  end

  initial begin
    sys_rst_n   = 1'b1;
    pll_locked  = 1'b1;
    sw_rst_req  = 1'b0;
    wdt_rst_req = 1'b0;
    #1 sys_rst_n = 1'b0;
    #1 check_now("reset", 8'b0001_0001);
    tick(2);

    // POR with lock already present
    base = cyc;
    sys_rst_n = 1'b1;
    expect_at(base + 4,  8'b1001_0001);
    expect_at(base + 8,  8'b1101_0001);
    expect_at(base + 12, 8'b1110_0001);
    tick(16);
    check_now("por_run", 8'b1110_0001);

    // single-cycle software request
    c = cyc;
    sw_rst_req = 1'b1;
    expect_at(c + 1,  8'b0001_0010);
    expect_at(c + 5,  8'b1001_0010);
    expect_at(c + 9,  8'b1101_0010);
    expect_at(c + 13, 8'b1110_0010);
    tick(1);
    sw_rst_req = 1'b0;
    tick(16);

    // simultaneous sw + wdt: one sequence, both cause bits
    c = cyc;
    sw_rst_req  = 1'b1;
    wdt_rst_req = 1'b1;
    expect_at(c + 1,  8'b0001_0110);
    expect_at(c + 5,  8'b1001_0110);
    expect_at(c + 9,  8'b1101_0110);
    expect_at(c + 13, 8'b1110_0110);
    tick(1);
    sw_rst_req  = 1'b0;
    wdt_rst_req = 1'b0;
    tick(16);

    // lock loss in RUN, then wait for relock
    c = cyc;
    pll_locked = 1'b0;
    expect_at(c + 1, 8'b0001_1000);
    tick(4 + LOCK_GAP);
    check_now("lock_wait_hold", 8'b0001_1000);
    d = cyc;
    pll_locked = 1'b1;
    expect_at(d + 1, 8'b1001_1000);
    expect_at(d + 5, 8'b1101_1000);
    expect_at(d + 9, 8'b1110_1000);
    tick(12);

    // async reset in RUN, then again mid REL_PERIPH
    expect_at(cyc, 8'b0001_0001);
    sys_rst_n = 1'b0;
    #1 check_now("async_run", 8'b0001_0001);
    tick(2);
    base = cyc;
    sys_rst_n = 1'b1;
    expect_at(base + 4, 8'b1001_0001);
    expect_at(base + 8, 8'b1101_0001);
    tick(9);
    expect_at(cyc, 8'b0001_0001);
    sys_rst_n = 1'b0;
    #1 check_now("async_periph", 8'b0001_0001);
    tick(2);
    base = cyc;
    sys_rst_n = 1'b1;
    expect_at(base + 4,  8'b1001_0001);
    expect_at(base + 8,  8'b1101_0001);
    expect_at(base + 12, 8'b1110_0001);
    tick(16);

`ifdef RST_LOCK_TIMEOUT_EN
    // lock never arrives: timeout forces release, no lock-loss retrigger
    expect_at(cyc, 8'b0001_0001);
    pll_locked = 1'b0;
    sys_rst_n  = 1'b0;
    tick(2);
    base = cyc;
    sys_rst_n = 1'b1;
    expect_at(base + 13, 8'b1001_1001);
    expect_at(base + 17, 8'b1101_1001);
    expect_at(base + 21, 8'b1110_1001);
    tick(35);
    check_now("no_retrigger", 8'b1110_1001);
`endif

    tick(4);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      $display("FAIL missing: want %b@%0d never seen", e.val, e.cyc);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
